muldiv_8088: RTL and testbench
==============================

Name: muldiv_8088

Overview:
Multi-cycle MUL/IMUL/DIV/IDIV execution unit for the 8088 datapath.
- Consumes operands read from register_bank_8088: AX, DX and the source operand.
- Computes iteratively: shift-add multiply, restoring divide.
- Sequences the implicit write-back of AX and DX into the register bank's write port.
- Sits between the register-bank read ports and its write port, alongside the ALU.

Parameters:
AX_IDX, 3'h0, register-bank index used for AX write-back
DX_IDX, 3'h3, register-bank index used for DX write-back

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-low reset
start  input  1  request; sampled only in IDLE
op  input  2  00 MUL, 01 IMUL, 10 DIV, 11 IDIV
size  input  1  0: byte operation, 1: word operation
ax_in  input  16  current AX (multiplicand / dividend low)
dx_in  input  16  current DX (dividend high, word DIV/IDIV only)
src_in  input  16  source operand; byte ops use [7:0]
busy  output  1  high from the cycle after start acceptance until done
done  output  1  one-cycle completion pulse
div_error  output  1  divide fault (type-0 interrupt request); valid only with done
cf_of  output  1  CF/OF result for MUL/IMUL; 0 for DIV/IDIV; held until next start
en_write  output  1  register-bank write enable
reg_write  output  3  register-bank write index
write_data  output  16  register-bank write data
wr_size  output  1  register-bank size; always 1 (16-bit writes)
wr_select_high_low  output  1  always 0

Behaviour:
- Reset (reset=0 at clk edge): state IDLE. All outputs 0. Internal accumulators cleared. Overrides any operation in progress, with no write-back.
- Operands and op/size are latched on the accepted start. Later input changes are ignored. start while busy is ignored.
- Iteration count N: 8 for byte, 16 for word.
- Signed ops: take magnitudes, run the unsigned core, then fix signs in the FIX state.
  - IMUL product is negated if operand signs differ.
  - IDIV quotient truncates toward zero. Remainder takes the dividend's sign.
- States:
  - IDLE -> CALC on start.
  - CALC runs N cycles, then -> FIX.
  - FIX: sign correction and error check, 1 cycle.
    - Error -> ERR.
    - Otherwise -> WB_LO.
  - WB_LO -> WB_HI if word, else -> IDLE.
  - WB_HI -> IDLE.
  - ERR -> IDLE.
- Timing, start accepted at cycle 0:
  - CALC occupies cycles 1..N. FIX is cycle N+1.
  - WB_LO is cycle N+2. WB_HI is cycle N+3.
  - done pulses in the final WB cycle or in ERR (ERR is cycle N+2).
  - Byte op: done at cycle 10. Word op: done at cycle 19.
- Write-back, with en_write=1 only in WB states:
  - Byte MUL/IMUL: WB_LO writes AX with the 16-bit product.
  - Word MUL/IMUL: WB_LO writes AX with product[15:0]; WB_HI writes DX with product[31:16].
  - Byte DIV/IDIV: WB_LO writes AX with {remainder[7:0], quotient[7:0]}.
  - Word DIV/IDIV: WB_LO writes AX with the quotient; WB_HI writes DX with the remainder.
- cf_of:
  - MUL: 1 iff the upper half of the product is nonzero.
  - IMUL: 1 iff the upper half is not the sign extension of the lower half.
- div_error is raised for any of these:
  - divisor = 0;
  - unsigned quotient > 0xFF (byte) or > 0xFFFF (word);
  - signed quotient outside -127..127 (byte) or -32767..32767 (word).
  - On error: en_write stays 0 and AX/DX are untouched.
- busy is high in CALC, FIX, WB_*, ERR. It drops in the cycle after done. A new start is accepted in that IDLE cycle.

Optional Feature:
MULDIV_EARLY_ZERO_EN
- Defined: a zero divisor on DIV/IDIV is detected at start acceptance. The FSM goes IDLE -> ERR directly, so done and div_error pulse at cycle 1 and CALC is skipped.
- Undefined: a zero divisor follows the normal flow, with done and div_error at cycle N+2.
- MUL/IMUL timing is identical in both builds.

Test Plan:
1. Byte MUL: ax_in=0x0012, src_in=0x0010 -> one write at cycle 10: reg_write=0, write_data=0x0120, cf_of=1, done=1.
2. Word MUL: ax_in=0x1234, src_in=0x0100 -> cycle 18 writes AX=0x3400, cycle 19 writes DX=0x0012 with done; cf_of=1.
3. Byte IMUL: ax_in=0x00FE, src_in=0x0003 -> AX=0xFFFA, cf_of=0.
4. Word DIV: dx_in=0x0001, ax_in=0x0000, src_in=0x0003 -> AX=0x5555, DX=0x0001, div_error=0. Byte IDIV: ax_in=0xFFF9, src_in=0x0002 -> AX=0xFFFD.
5. Errors, each giving div_error=1 with done and en_write never asserted:
   - byte DIV, ax_in=0x0400, src_in=0x02;
   - DIV with src_in=0 -> done at cycle 10 (byte) without the macro, cycle 1 with it.
6. Word MUL, reset=0 at cycle 5 -> next cycle busy=0, no write-back. Then start with a new op -> correct result. start pulsed while busy -> ignored.

Source files
------------

// File: rtl/muldiv_8088.sv
`default_nettype none
// =============================================================================
// muldiv_8088 : iterative MUL/IMUL/DIV/IDIV unit with AX/DX write-back sequencing
// Optional: MULDIV_EARLY_ZERO_EN (zero divisor faults at start acceptance)
// Revision 1.0
// =============================================================================
module muldiv_8088 #(
    parameter logic [2:0] AX_IDX = 3'h0,
    parameter logic [2:0] DX_IDX = 3'h3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic        size,
    input  logic [15:0] ax_in,
    input  logic [15:0] dx_in,
    input  logic [15:0] src_in,
    output logic        busy,
    output logic        done,
    output logic        div_error,
    output logic        cf_of,
    output logic        en_write,
    output logic [2:0]  reg_write,
    output logic [15:0] write_data,
    output logic        wr_size,
    output logic        wr_select_high_low
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CALC  = 3'd1,
        S_FIX   = 3'd2,
        S_WB_LO = 3'd3,
        S_WB_HI = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [1:0]  r_op;
    logic        r_size;
    logic        r_neg_res;
    logic        r_neg_dvd;
    logic        r_ovf;
    logic        r_cf;
    logic [3:0]  r_cnt;
    logic [31:0] r_acc;
    logic [31:0] r_opa;
    logic [15:0] r_opb;
    logic [15:0] r_wb_lo;
    logic [15:0] r_wb_hi;

    // Operand conditioning at acceptance: extend to 16/32 bits, then take magnitudes.
    logic [15:0] w_a_ext, w_s_ext, w_a_mag, w_s_mag;
    logic [31:0] w_d_ext, w_d_mag;
    logic [15:0] w_d_hi, w_d_lo;
    logic        w_a_neg, w_s_neg, w_d_neg, w_ovf;

    always_comb begin
        w_a_ext = size ? ax_in  : (op[0] ? {{8{ax_in[7]}},  ax_in[7:0]}  : {8'h00, ax_in[7:0]});
        w_s_ext = size ? src_in : (op[0] ? {{8{src_in[7]}}, src_in[7:0]} : {8'h00, src_in[7:0]});
        w_d_ext = size ? {dx_in, ax_in} : (op[0] ? {{16{ax_in[15]}}, ax_in} : {16'h0000, ax_in});
        w_a_neg = op[0] & w_a_ext[15];
        w_s_neg = op[0] & w_s_ext[15];
        w_d_neg = op[0] & w_d_ext[31];
        w_a_mag = w_a_neg ? -w_a_ext : w_a_ext;
        w_s_mag = w_s_neg ? -w_s_ext : w_s_ext;
        w_d_mag = w_d_neg ? -w_d_ext : w_d_ext;
        // Byte dividend low half sits in the top of the quotient shifter so the
        // bit fed into the remainder is always bit 15.
        w_d_hi  = size ? w_d_mag[31:16] : {8'h00, w_d_mag[15:8]};
        w_d_lo  = size ? w_d_mag[15:0]  : {w_d_mag[7:0], 8'h00};
        // Quotient needs more than N bits exactly when the high half reaches the divisor.
        w_ovf   = (w_s_mag == 16'h0000) | (w_d_hi >= w_s_mag);
    end

    // Restoring divide step on {remainder, quotient} held in r_acc.
    logic [16:0] w_shl;
    logic [17:0] w_diff;
    logic        w_fit;
    logic [31:0] w_div_step;

    always_comb begin
        w_shl      = {r_acc[31:16], r_acc[15]};
        w_diff     = {1'b0, w_shl} - {2'b00, r_opa[15:0]};
        w_fit      = ~w_diff[17];
        w_div_step = {(w_fit ? w_diff[15:0] : w_shl[15:0]), r_acc[14:0], w_fit};
    end

    logic [31:0] w_prod_s;
    logic [15:0] w_quo, w_rem, w_quo_s, w_rem_s;
    logic        w_div_err, w_mul_cf;

    always_comb begin
        w_prod_s  = r_neg_res ? -r_acc : r_acc;
        w_quo     = r_size ? r_acc[15:0] : {8'h00, r_acc[7:0]};
        w_rem     = r_acc[31:16];
        w_quo_s   = r_neg_res ? -w_quo : w_quo;
        w_rem_s   = r_neg_dvd ? -w_rem : w_rem;
        w_div_err = r_op[1] & (r_ovf | (r_op[0] & (r_size ? w_quo[15] : w_quo[7])));
        if (r_op[0]) begin
            w_mul_cf = r_size ? (w_prod_s[31:16] != {16{w_prod_s[15]}})
                              : (w_prod_s[15:8]  != {8{w_prod_s[7]}});
        end else begin
            w_mul_cf = r_size ? (|r_acc[31:16]) : (|r_acc[15:8]);
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
`ifdef MULDIV_EARLY_ZERO_EN
                    w_next = (op[1] && (w_s_mag == 16'h0000)) ? S_ERR : S_CALC;
`else
                    w_next = S_CALC;
`endif
                end
            end
            S_CALC:  if (r_cnt == 4'd0) w_next = S_FIX;
            S_FIX:   w_next = w_div_err ? S_ERR : S_WB_LO;
            S_WB_LO: w_next = r_size ? S_WB_HI : S_IDLE;
            S_WB_HI: w_next = S_IDLE;
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_op      <= 2'b00;
            r_size    <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_dvd <= 1'b0;
            r_ovf     <= 1'b0;
            r_cf      <= 1'b0;
            r_cnt     <= 4'd0;
            r_acc     <= 32'h0;
            r_opa     <= 32'h0;
            r_opb     <= 16'h0;
            r_wb_lo   <= 16'h0;
            r_wb_hi   <= 16'h0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op   <= op;
                        r_size <= size;
                        r_cnt  <= size ? 4'd15 : 4'd7;
                        r_cf   <= 1'b0;
                        if (op[1]) begin
                            r_acc     <= {w_d_hi, w_d_lo};
                            r_opa     <= {16'h0000, w_s_mag};
                            r_opb     <= 16'h0000;
                            r_neg_res <= w_d_neg ^ w_s_neg;
                            r_neg_dvd <= w_d_neg;
                            r_ovf     <= w_ovf;
                        end else begin
                            r_acc     <= 32'h0;
                            r_opa     <= {16'h0000, w_a_mag};
                            r_opb     <= w_s_mag;
                            r_neg_res <= w_a_neg ^ w_s_neg;
                            r_neg_dvd <= 1'b0;
                            r_ovf     <= 1'b0;
                        end
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_op[1]) begin
                        r_acc <= w_div_step;
                    end else begin
                        if (r_opb[0]) r_acc <= r_acc + r_opa;
                        r_opa <= {r_opa[30:0], 1'b0};
                        r_opb <= {1'b0, r_opb[15:1]};
                    end
                end
                S_FIX: begin
                    r_wb_lo <= r_op[1] ? (r_size ? w_quo_s : {w_rem_s[7:0], w_quo_s[7:0]})
                                       : w_prod_s[15:0];
                    r_wb_hi <= r_op[1] ? w_rem_s : w_prod_s[31:16];
                    r_cf    <= ~r_op[1] & w_mul_cf;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy               = (r_state != S_IDLE);
        done               = 1'b0;
        div_error          = 1'b0;
        en_write           = 1'b0;
        reg_write          = 3'd0;
        write_data         = 16'h0000;
        cf_of              = r_cf;
        wr_size            = 1'b1;
        wr_select_high_low = 1'b0;
        case (r_state)
            S_WB_LO: begin
                en_write   = 1'b1;
                reg_write  = AX_IDX;
                write_data = r_wb_lo;
                done       = ~r_size;
            end
            S_WB_HI: begin
                en_write   = 1'b1;
                reg_write  = DX_IDX;
                write_data = r_wb_hi;
                done       = 1'b1;
            end
            S_ERR: begin
                done      = 1'b1;
                div_error = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_8088.sv
`default_nettype none
// =============================================================================
// tb_muldiv_8088 : scoreboard bench for muldiv_8088 (honours MULDIV_EARLY_ZERO_EN)
// Revision 1.0
// =============================================================================
module tb_muldiv_8088;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic        size = 1'b0;
    logic [15:0] ax_in = 16'h0, dx_in = 16'h0, src_in = 16'h0;
    logic        busy, done, div_error, cf_of, en_write, wr_size, wr_select_high_low;
    logic [2:0]  reg_write;
    logic [15:0] write_data;

    int checks = 0;
    int errors = 0;

    muldiv_8088 #(.AX_IDX(3'h0), .DX_IDX(3'h3)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .size(size),
        .ax_in(ax_in), .dx_in(dx_in), .src_in(src_in),
        .busy(busy), .done(done), .div_error(div_error), .cf_of(cf_of),
        .en_write(en_write), .reg_write(reg_write), .write_data(write_data),
        .wr_size(wr_size), .wr_select_high_low(wr_select_high_low)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  cyc;
        logic [2:0]  idx;
        logic [15:0] data;
        logic        dn;
        logic        sz;
    } wr_t;

    typedef struct packed {
        logic [1:0]  o;
        logic        s;
        logic [15:0] a;
        logic [15:0] d;
        logic [15:0] sr;
    } vec_t;

    wr_t exp_q[$];
    wr_t obs_q[$];
    int  done_cyc;
    logic obs_err, obs_cf;
    bit  busy_bad;

    // Reference arithmetic on wide signed integers.
    task automatic model(input logic [1:0] o, input logic s, input logic [15:0] a, d, sr,
                         output bit err, output bit cf, output logic [15:0] lo, output logic [15:0] hi);
        longint x, y, p, q, r;
        byte b8;
        shortint b16;
        int i32;
        err = 0; cf = 0; lo = 16'h0; hi = 16'h0;
        if (!o[1]) begin
            if (o[0]) begin
                if (s) begin b16 = a; x = b16; b16 = sr; y = b16; end
                else begin b8 = a[7:0]; x = b8; b8 = sr[7:0]; y = b8; end
            end else begin
                x = s ? longint'(a)  : longint'(a[7:0]);
                y = s ? longint'(sr) : longint'(sr[7:0]);
            end
            p  = x * y;
            lo = p[15:0];
            hi = p[31:16];
            if (o[0]) cf = s ? (p < -32768 || p > 32767) : (p < -128 || p > 127);
            else      cf = s ? (p > 65535) : (p > 255);
        end else begin
            if (o[0]) begin
                if (s) begin i32 = {d, a}; x = i32; b16 = sr; y = b16; end
                else begin b16 = a; x = b16; b8 = sr[7:0]; y = b8; end
            end else begin
                x = s ? longint'({d, a}) : longint'(a);
                y = s ? longint'(sr) : longint'(sr[7:0]);
            end
            if (y == 0) begin
                err = 1;
            end else begin
                q = x / y;
                r = x % y;
                if (o[0]) err = s ? (q > 32767 || q < -32767) : (q > 127 || q < -127);
                else      err = s ? (q > 65535) : (q > 255);
                lo = s ? q[15:0] : {r[7:0], q[7:0]};
                hi = r[15:0];
            end
        end
    endtask

    task automatic expect_op(input vec_t v, output bit e_err, output bit e_cf, output int e_done);
        logic [15:0] lo, hi;
        int n;
        model(v.o, v.s, v.a, v.d, v.sr, e_err, e_cf, lo, hi);
        n = v.s ? 16 : 8;
        exp_q.delete();
        if (e_err) begin
            e_done = n + 2;
`ifdef MULDIV_EARLY_ZERO_EN
            if (v.o[1] && ((v.s ? v.sr : {8'h00, v.sr[7:0]}) == 16'h0)) e_done = 1;
`endif
        end else begin
            exp_q.push_back('{8'(n + 2), 3'd0, lo, ~v.s, 1'b1});
            if (v.s) exp_q.push_back('{8'(n + 3), 3'd3, hi, 1'b1, 1'b1});
            e_done = v.s ? n + 3 : n + 2;
        end
    endtask

    // Drives start in the low phase; returns just after the accepting edge, inputs scrambled.
    task automatic launch(input vec_t v);
        @(negedge clk);
        start = 1'b1; op = v.o; size = v.s; ax_in = v.a; dx_in = v.d; src_in = v.sr;
        @(posedge clk);
        #1;
        start = 1'b0;
        op = 2'($urandom); size = 1'($urandom);
        ax_in = 16'($urandom); dx_in = 16'($urandom); src_in = 16'($urandom);
    endtask

    // Records writes and completion, cycle-numbered from the accept cycle (cycle 0).
    task automatic capture(input int c0, input int budget);
        obs_q.delete();
        done_cyc = -1;
        busy_bad = 0;
        obs_err  = 1'bx;
        obs_cf   = 1'bx;
        for (int c = c0; c < c0 + budget && done_cyc < 0; c++) begin
            @(negedge clk);
            if (!busy) busy_bad = 1;
            if (en_write) obs_q.push_back('{8'(c), reg_write, write_data, done, wr_size});
            if (done) begin
                done_cyc = c;
                obs_err  = div_error;
                obs_cf   = cf_of;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (en_write !== 1'b0) begin errors++; $display("FAIL reset_en_write: got %b expected 0", en_write); end
        checks++; if (div_error !== 1'b0) begin errors++; $display("FAIL reset_div_error: got %b expected 0", div_error); end
        checks++; if (cf_of !== 1'b0) begin errors++; $display("FAIL reset_cf_of: got %b expected 0", cf_of); end
        checks++; if (write_data !== 16'h0) begin errors++; $display("FAIL reset_write_data: got %h expected 0000", write_data); end
        checks++; if (reg_write !== 3'd0) begin errors++; $display("FAIL reset_reg_write: got %h expected 0", reg_write); end
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_arith();
        vec_t tbl[$];
        vec_t v;
        bit e_err, e_cf;
        int e_done;
        wr_t ew, ow;
        tbl.push_back('{2'd0, 1'b0, 16'h0012, 16'h0000, 16'h0010});
        tbl.push_back('{2'd0, 1'b1, 16'h1234, 16'h0000, 16'h0100});
        tbl.push_back('{2'd1, 1'b0, 16'h00FE, 16'h0000, 16'h0003});
        tbl.push_back('{2'd2, 1'b1, 16'h0000, 16'h0001, 16'h0003});
        tbl.push_back('{2'd3, 1'b0, 16'hFFF9, 16'h0000, 16'h0002});
        tbl.push_back('{2'd1, 1'b0, 16'h0080, 16'h0000, 16'h0080});
        tbl.push_back('{2'd1, 1'b1, 16'h8000, 16'h0000, 16'hFFFF});
        tbl.push_back('{2'd0, 1'b1, 16'hFFFF, 16'h0000, 16'hFFFF});
        tbl.push_back('{2'd3, 1'b0, 16'h007F, 16'h0000, 16'h0001});
        tbl.push_back('{2'd3, 1'b0, 16'hFF81, 16'h0000, 16'h0001});
        tbl.push_back('{2'd3, 1'b1, 16'h8001, 16'hFFFF, 16'h0001});
        tbl.push_back('{2'd2, 1'b0, 16'h00FF, 16'h0000, 16'h0001});
        for (int i = 0; i < 40; i++) begin
            v.o  = 2'($urandom);
            v.s  = 1'($urandom);
            v.a  = 16'($urandom);
            v.sr = 16'($urandom);
            v.d  = $urandom_range(0, 1) ? {16{v.a[15]}} : (16'($urandom) & 16'h000F);
            tbl.push_back(v);
        end
        foreach (tbl[k]) begin
            expect_op(tbl[k], e_err, e_cf, e_done);
            launch(tbl[k]);
            capture(1, 40);
            checks++;
            if (done_cyc !== e_done) begin errors++; $display("FAIL arith_done_cycle[%0d]: got %0d expected %0d", k, done_cyc, e_done); end
            checks++;
            if (obs_err !== e_err) begin errors++; $display("FAIL arith_div_error[%0d]: got %b expected %b", k, obs_err, e_err); end
            checks++;
            if (obs_cf !== e_cf) begin errors++; $display("FAIL arith_cf_of[%0d]: got %b expected %b", k, obs_cf, e_cf); end
            checks++;
            if (busy_bad) begin errors++; $display("FAIL arith_busy[%0d]: got 0 expected 1", k); end
            checks++;
            if (obs_q.size() != exp_q.size()) begin
                errors++; $display("FAIL arith_write_count[%0d]: got %0d expected %0d", k, obs_q.size(), exp_q.size());
            end
            while (exp_q.size() > 0 && obs_q.size() > 0) begin
                ew = exp_q.pop_front();
                ow = obs_q.pop_front();
                checks++;
                if (ow !== ew) begin
                    errors++;
                    $display("FAIL arith_write[%0d]: got cyc=%0d idx=%0d data=%h done=%b sz=%b expected cyc=%0d idx=%0d data=%h done=%b sz=%b",
                             k, ow.cyc, ow.idx, ow.data, ow.dn, ow.sz, ew.cyc, ew.idx, ew.data, ew.dn, ew.sz);
                end
            end
        end
    endtask

    task automatic test_div_error();
        vec_t tbl[$];
        bit e_err, e_cf;
        int e_done;
        tbl.push_back('{2'd2, 1'b0, 16'h0400, 16'h0000, 16'h0002});
        tbl.push_back('{2'd2, 1'b0, 16'h1234, 16'h0000, 16'hFF00});
        tbl.push_back('{2'd2, 1'b1, 16'h0000, 16'h0005, 16'h0000});
        tbl.push_back('{2'd3, 1'b0, 16'h0050, 16'h0000, 16'h0000});
        tbl.push_back('{2'd3, 1'b0, 16'hFF80, 16'h0000, 16'h0001});
        tbl.push_back('{2'd3, 1'b1, 16'h8000, 16'hFFFF, 16'h0001});
        tbl.push_back('{2'd2, 1'b1, 16'h0000, 16'h0003, 16'h0003});
        tbl.push_back('{2'd3, 1'b0, 16'h0100, 16'h0000, 16'h0002});
        foreach (tbl[k]) begin
            expect_op(tbl[k], e_err, e_cf, e_done);
            launch(tbl[k]);
            capture(1, 40);
            checks++;
            if (obs_err !== 1'b1) begin errors++; $display("FAIL err_flag[%0d]: got %b expected 1", k, obs_err); end
            checks++;
            if (done_cyc !== e_done) begin errors++; $display("FAIL err_done_cycle[%0d]: got %0d expected %0d", k, done_cyc, e_done); end
            checks++;
            if (obs_q.size() != 0) begin errors++; $display("FAIL err_no_write[%0d]: got %0d writes expected 0", k, obs_q.size()); end
            checks++;
            if (obs_cf !== 1'b0) begin errors++; $display("FAIL err_cf_of[%0d]: got %b expected 0", k, obs_cf); end
        end
    endtask

    task automatic test_reset_abort();
        vec_t v;
        bit e_err, e_cf;
        int e_done;
        int stray;
        v = '{2'd0, 1'b1, 16'h1234, 16'h0000, 16'h0100};
        launch(v);
        repeat (4) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
        checks++; if (cf_of !== 1'b0) begin errors++; $display("FAIL abort_cf_of: got %b expected 0", cf_of); end
        stray = 0;
        repeat (25) begin
            @(negedge clk);
            if (en_write || done || busy) stray++;
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL abort_no_writeback: got %0d active cycles expected 0", stray); end
        v = '{2'd3, 1'b0, 16'hFFF9, 16'h0000, 16'h0002};
        expect_op(v, e_err, e_cf, e_done);
        launch(v);
        capture(1, 40);
        checks++; if (done_cyc !== e_done) begin errors++; $display("FAIL abort_next_done: got %0d expected %0d", done_cyc, e_done); end
        checks++;
        if (obs_q.size() != 1 || obs_q[0].data !== exp_q[0].data) begin
            errors++; $display("FAIL abort_next_data: got %0d writes expected AX=%h", obs_q.size(), exp_q[0].data);
        end
        // A second start mid-operation must not disturb or queue anything.
        v = '{2'd0, 1'b0, 16'h0012, 16'h0000, 16'h0010};
        expect_op(v, e_err, e_cf, e_done);
        launch(v);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1; op = 2'd2; size = 1'b0; ax_in = 16'h0400; src_in = 16'h0000;
        @(posedge clk);
        #1 start = 1'b0;
        capture(4, 40);
        checks++; if (done_cyc !== e_done) begin errors++; $display("FAIL busy_start_done: got %0d expected %0d", done_cyc, e_done); end
        checks++; if (obs_err !== 1'b0) begin errors++; $display("FAIL busy_start_err: got %b expected 0", obs_err); end
        checks++;
        if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
            errors++; $display("FAIL busy_start_write: got %0d writes expected 1 with data %h", obs_q.size(), exp_q[0].data);
        end
        stray = 0;
        repeat (15) begin
            @(negedge clk);
            if (busy) stray++;
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL busy_start_ignored: got %0d busy cycles expected 0", stray); end
    endtask

    task automatic test_back_to_back();
        vec_t v1, v2;
        bit e_err, e_cf;
        int e_done;
        v1 = '{2'd0, 1'b1, 16'hBEEF, 16'h0000, 16'h1234};
        v2 = '{2'd1, 1'b0, 16'h0085, 16'h0000, 16'h0007};
        expect_op(v1, e_err, e_cf, e_done);
        launch(v1);
        capture(1, 40);
        checks++; if (done_cyc !== e_done) begin errors++; $display("FAIL b2b_first_done: got %0d expected %0d", done_cyc, e_done); end
        checks++; if (obs_q.size() != 2 || obs_q[1] !== exp_q[1]) begin errors++; $display("FAIL b2b_first_dx: got %0d writes expected DX=%h", obs_q.size(), exp_q[1].data); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy: got %b expected 0", busy); end
        start = 1'b1; op = v2.o; size = v2.s; ax_in = v2.a; dx_in = v2.d; src_in = v2.sr;
        expect_op(v2, e_err, e_cf, e_done);
        @(posedge clk);
        #1 start = 1'b0; ax_in = 16'h0;
        capture(1, 40);
        checks++; if (done_cyc !== e_done) begin errors++; $display("FAIL b2b_second_done: got %0d expected %0d", done_cyc, e_done); end
        checks++; if (obs_cf !== e_cf) begin errors++; $display("FAIL b2b_second_cf: got %b expected %b", obs_cf, e_cf); end
        checks++; if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin errors++; $display("FAIL b2b_second_ax: got %0d writes expected AX=%h", obs_q.size(), exp_q[0].data); end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_div_error();
        test_reset_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
